// File: rtl/program_sayaci_uretici_pkg.sv
// Shared constants and FSM encoding for the fetch-stage PC generator.
// Imported by the PC generator and by the fetch top level.
package program_sayaci_uretici_pkg;

    localparam int BUYRUK_W = 32;
    localparam logic [31:0] BASLANGIC_PS_VARSAYILAN = 32'h4000_0000;

    typedef enum logic [1:0] {
        ISTEK = 2'd0,
        BEKLE = 2'd1,
        IPTAL = 2'd2
    } durum_t;

endpackage

// File: rtl/program_sayaci_uretici.sv
// Fetch PC generator: one outstanding instruction request,
// predictor-driven next PC, flush/redirect and a registered output.
module program_sayaci_uretici
    import program_sayaci_uretici_pkg::*;
#(
    parameter logic [31:0] BASLANGIC_PS = BASLANGIC_PS_VARSAYILAN
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                durdur_i,
    input  logic                dallanma_hata_i,
    input  logic [31:0]         dogru_ps_i,
    output logic [31:0]         ps_o,
    output logic                ongoru_aktif_o,
    input  logic                ongoru_gecerli_i,
    input  logic [31:0]         atlanan_ps_i,
    output logic                istek_gecerli_o,
    input  logic                istek_hazir_i,
    output logic [31:0]         istek_adres_o,
    input  logic                yanit_gecerli_i,
    input  logic [BUYRUK_W-1:0] yanit_buyruk_i,
    output logic                buyruk_gecerli_o,
    output logic [BUYRUK_W-1:0] buyruk_o,
    output logic [31:0]         buyruk_ps_o,
    output logic                buyruk_ongoru_o
);

    durum_t      durum;
    logic [31:0] ps_q;
    logic [31:0] ps_arti4;
    logic [31:0] bekleyen_ps_q;
    logic        bekleyen_ong_q;
    logic        cikis_bos;
    logic        istek_v;
    logic        kabul;
    logic        ong_alindi;

    assign ps_arti4  = ps_q + 32'd4;
    assign cikis_bos = !buyruk_gecerli_o || !durdur_i;

    // A flush cycle never issues; reset gating keeps the port quiet
    // while the registers are being forced.
    assign istek_v = !rst_i && (durum == ISTEK) && !durdur_i
                     && cikis_bos && !dallanma_hata_i;
    assign kabul   = istek_v && istek_hazir_i;

    // A hit whose target is the fall-through is not a taken branch.
    assign ong_alindi = ongoru_gecerli_i && (atlanan_ps_i != ps_arti4);

    assign ps_o            = ps_q;
    assign istek_adres_o   = ps_q;
    assign istek_gecerli_o = istek_v;
    assign ongoru_aktif_o  = istek_v;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum            <= ISTEK;
            ps_q             <= BASLANGIC_PS;
            bekleyen_ps_q    <= '0;
            bekleyen_ong_q   <= 1'b0;
            buyruk_gecerli_o <= 1'b0;
            buyruk_o         <= '0;
            buyruk_ps_o      <= '0;
            buyruk_ongoru_o  <= 1'b0;
        end else if (dallanma_hata_i) begin
            ps_q             <= dogru_ps_i;
            buyruk_gecerli_o <= 1'b0;
            unique case (durum)
                ISTEK:   durum <= kabul ? IPTAL : ISTEK;
                BEKLE:   durum <= yanit_gecerli_i ? ISTEK : IPTAL;
                IPTAL:   durum <= yanit_gecerli_i ? ISTEK : IPTAL;
                default: durum <= ISTEK;
            endcase
        end else begin
            if (!durdur_i) begin
                buyruk_gecerli_o <= 1'b0;
            end
            unique case (durum)
                ISTEK: begin
                    if (kabul) begin
                        bekleyen_ps_q  <= ps_q;
                        bekleyen_ong_q <= ong_alindi;
                        ps_q  <= ongoru_gecerli_i ? atlanan_ps_i : ps_arti4;
                        durum <= BEKLE;
                    end
                end
                BEKLE: begin
                    if (yanit_gecerli_i) begin
                        buyruk_o         <= yanit_buyruk_i;
                        buyruk_ps_o      <= bekleyen_ps_q;
                        buyruk_ongoru_o  <= bekleyen_ong_q;
                        buyruk_gecerli_o <= 1'b1;
                        durum            <= ISTEK;
                    end
                end
                IPTAL: begin
                    if (yanit_gecerli_i) begin
                        durum <= ISTEK;
                    end
                end
                default: durum <= ISTEK;
            endcase
        end
    end

endmodule

// File: tb/tb_program_sayaci_uretici.sv
// Directed and randomized bench for the fetch PC generator with a
// transaction-level memory, predictor and expected-PC model.
module tb_program_sayaci_uretici;

    localparam logic [31:0] BAS = 32'h4000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        durdur_i = 1'b0;
    logic        dallanma_hata_i = 1'b0;
    logic [31:0] dogru_ps_i = '0;
    logic [31:0] ps_o;
    logic        ongoru_aktif_o;
    logic        ongoru_gecerli_i;
    logic [31:0] atlanan_ps_i;
    logic        istek_gecerli_o;
    logic        istek_hazir_i = 1'b0;
    logic [31:0] istek_adres_o;
    logic        yanit_gecerli_i = 1'b0;
    logic [31:0] yanit_buyruk_i = '0;
    logic        buyruk_gecerli_o;
    logic [31:0] buyruk_o;
    logic [31:0] buyruk_ps_o;
    logic        buyruk_ongoru_o;

    int testler = 0;
    int hatalar = 0;

    // predictor configuration: 0 none, 1 single entry, 2 pattern
    logic [1:0]  ong_mod = 2'd0;
    logic [31:0] ong_pc = '0;
    logic [31:0] ong_hedef = '0;

    // memory responder state
    logic        r_bekle = 1'b0;
    logic [31:0] r_adr = '0;
    int          r_say = 0;
    int          gecikme = 0;
    logic [31:0] istekler[$];

    // expected-behaviour model
    logic [31:0] m_pc;
    logic        m_mesgul;
    logic        m_bayat;
    logic [31:0] m_ppc;
    logic        m_pong;
    logic        m_gec;
    logic [31:0] m_buy;
    logic [31:0] m_bps;
    logic        m_bong;

    logic        ong8 = 1'b0;
    int          gecerli_say = 0;

    program_sayaci_uretici #(.BASLANGIC_PS(BAS)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .durdur_i(durdur_i),
        .dallanma_hata_i(dallanma_hata_i),
        .dogru_ps_i(dogru_ps_i),
        .ps_o(ps_o),
        .ongoru_aktif_o(ongoru_aktif_o),
        .ongoru_gecerli_i(ongoru_gecerli_i),
        .atlanan_ps_i(atlanan_ps_i),
        .istek_gecerli_o(istek_gecerli_o),
        .istek_hazir_i(istek_hazir_i),
        .istek_adres_o(istek_adres_o),
        .yanit_gecerli_i(yanit_gecerli_i),
        .yanit_buyruk_i(yanit_buyruk_i),
        .buyruk_gecerli_o(buyruk_gecerli_o),
        .buyruk_o(buyruk_o),
        .buyruk_ps_o(buyruk_ps_o),
        .buyruk_ongoru_o(buyruk_ongoru_o)
    );

    always #5 clk_i = ~clk_i;

    assign ongoru_gecerli_i =
        (ong_mod == 2'd1) ? (ps_o == ong_pc) :
        (ong_mod == 2'd2) ? (ps_o[4:2] == 3'b101) : 1'b0;
    assign atlanan_ps_i =
        (ong_mod == 2'd1) ? ong_hedef :
        (ps_o[5] ? ps_o + 32'd4 : ps_o + 32'h40);

    function automatic logic [31:0] bellek(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        if (ong_mod == 2'd1) return pc == ong_pc;
        if (ong_mod == 2'd2) return pc[4:2] == 3'b101;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_hedef(input logic [31:0] pc);
        if (ong_mod == 2'd1) return ong_hedef;
        return pc[5] ? pc + 32'd4 : pc + 32'h40;
    endfunction

    function automatic logic [31:0] istek_al(input int i);
        if (i < istekler.size()) return istekler[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] gor,
                       input logic [31:0] bek);
        testler++;
        assert (gor === bek) else begin
            hatalar++;
            $error("FAIL %s: observed %h expected %h", tag, gor, bek);
        end
    endtask

    task automatic model_sifirla();
        m_pc = BAS; m_mesgul = 0; m_bayat = 0;
        m_ppc = '0; m_pong = 0; m_gec = 0;
        m_buy = '0; m_bps = '0; m_bong = 0;
        r_bekle = 0; r_say = 0;
    endtask

    task automatic sifirla();
        #2 rst_i = 1'b1;
        #1;
        durdur_i = 0; dallanma_hata_i = 0; istek_hazir_i = 0;
        yanit_gecerli_i = 0; yanit_buyruk_i = '0;
        chk("rst_ps", ps_o, BAS);
        chk("rst_istek", {31'd0, istek_gecerli_o}, 32'd0);
        chk("rst_ongoru_aktif", {31'd0, ongoru_aktif_o}, 32'd0);
        chk("rst_gecerli", {31'd0, buyruk_gecerli_o}, 32'd0);
        chk("rst_buyruk", buyruk_o, 32'd0);
        chk("rst_buyruk_ps", buyruk_ps_o, 32'd0);
        chk("rst_buyruk_ong", {31'd0, buyruk_ongoru_o}, 32'd0);
        model_sifirla();
        @(posedge clk_i);
        @(negedge clk_i);
        istek_hazir_i = 1'b1;
        #1 chk("rst_istek_hold", {31'd0, istek_gecerli_o}, 32'd0);
        rst_i = 1'b0;
    endtask

    // One clock: drive inputs, check outputs against the model,
    // advance model and memory, then move to the next falling edge.
    task automatic tik(input logic d, input logic f,
                       input logic [31:0] dp, input logic h);
        logic e_istek;
        logic kab;
        durdur_i = d;
        dallanma_hata_i = f;
        dogru_ps_i = dp;
        istek_hazir_i = h;
        yanit_gecerli_i = r_bekle && (r_say == 0);
        yanit_buyruk_i = yanit_gecerli_i ? bellek(r_adr) : 32'd0;
        #1;
        e_istek = !m_mesgul && !d && !f;
        chk("istek_gecerli", {31'd0, istek_gecerli_o}, {31'd0, e_istek});
        chk("ongoru_aktif", {31'd0, ongoru_aktif_o}, {31'd0, e_istek});
        chk("ps", ps_o, m_pc);
        if (e_istek) chk("istek_adres", istek_adres_o, m_pc);
        chk("buyruk_gecerli", {31'd0, buyruk_gecerli_o}, {31'd0, m_gec});
        if (m_gec) begin
            chk("buyruk", buyruk_o, m_buy);
            chk("buyruk_ps", buyruk_ps_o, m_bps);
            chk("buyruk_ongoru", {31'd0, buyruk_ongoru_o}, {31'd0, m_bong});
        end
        if (buyruk_gecerli_o === 1'b1) begin
            gecerli_say++;
            if (buyruk_ps_o == 32'h4000_0008) ong8 = buyruk_ongoru_o;
        end

        kab = e_istek && h;
        if (f) m_gec = 0;
        else if (m_mesgul && !m_bayat && yanit_gecerli_i) begin
            m_gec = 1; m_buy = bellek(m_ppc);
            m_bps = m_ppc; m_bong = m_pong;
        end else if (!d) m_gec = 0;
        if (kab) begin
            m_ppc = m_pc;
            m_pong = m_hit(m_pc) && (m_hedef(m_pc) != m_pc + 32'd4);
            m_pc = m_hit(m_pc) ? m_hedef(m_pc) : m_pc + 32'd4;
        end
        if (f) m_pc = dp;
        if (m_mesgul && yanit_gecerli_i) m_mesgul = 0;
        else if (m_mesgul && f) m_bayat = 1;
        if (kab) begin m_mesgul = 1; m_bayat = 0; end

        if (yanit_gecerli_i) r_bekle = 0;
        if (istek_gecerli_o === 1'b1 && h) begin
            r_bekle = 1; r_adr = istek_adres_o; r_say = gecikme;
            istekler.push_back(istek_adres_o);
        end else if (r_bekle && r_say > 0) r_say--;
        @(negedge clk_i);
    endtask

    task automatic bosa_bekle();
        for (int i = 0; i < 10 && m_mesgul; i++) tik(0, 0, '0, 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] tut_buy;
        logic [31:0] tut_pc;
        model_sifirla();
        @(negedge clk_i);
        sifirla();

        // sequential fetch, predictor hit at 0008 -> 0100
        ong_mod = 2'd1; ong_pc = 32'h4000_0008; ong_hedef = 32'h4000_0100;
        gecikme = 0;
        istekler.delete();
        for (int i = 0; i < 10; i++) tik(0, 0, '0, 1);
        chk("seq0", istek_al(0), 32'h4000_0000);
        chk("seq1", istek_al(1), 32'h4000_0004);
        chk("seq2", istek_al(2), 32'h4000_0008);
        chk("pred_target", istek_al(3), 32'h4000_0100);
        chk("pred_flag_0008", {31'd0, ong8}, 32'd1);

        // flush while awaiting a response
        ong_mod = 2'd0;
        bosa_bekle();
        gecikme = 2;
        for (int i = 0; i < 10 && !m_mesgul; i++) tik(0, 0, '0, 1);
        istekler.delete();
        gecikme = 0;
        gecerli_say = 0;
        tik(0, 1, 32'h4000_0200, 1);
        for (int i = 0; i < 3; i++) tik(0, 0, '0, 1);
        chk("flush_no_valid", gecerli_say, 0);
        for (int i = 0; i < 4; i++) tik(0, 0, '0, 1);
        chk("flush_redirect", istek_al(0), 32'h4000_0200);

        // stall with valid output
        for (int i = 0; i < 10 && !m_gec; i++) tik(0, 0, '0, 1);
        tut_buy = m_buy;
        tut_pc = m_pc;
        istekler.delete();
        for (int i = 0; i < 3; i++) begin
            tik(1, 0, '0, 1);
            chk("stall_buyruk", buyruk_o, tut_buy);
        end
        chk("stall_no_req", istekler.size(), 0);
        tik(0, 0, '0, 1);
        chk("stall_resume", istek_al(0), tut_pc);

        // memory not ready, predictor active
        ong_mod = 2'd2;
        bosa_bekle();
        for (int i = 0; i < 3; i++) tik(0, 0, '0, 1);
        bosa_bekle();
        tut_pc = m_pc;
        for (int i = 0; i < 4; i++) begin
            tik(0, 0, '0, 0);
            chk("notready_ps", ps_o, tut_pc);
        end
        for (int i = 0; i < 4; i++) tik(0, 0, '0, 1);

        // address wrap
        ong_mod = 2'd0;
        bosa_bekle();
        tik(0, 1, 32'hFFFF_FFFC, 1);
        istekler.delete();
        for (int i = 0; i < 4; i++) tik(0, 0, '0, 1);
        chk("wrap0", istek_al(0), 32'hFFFF_FFFC);
        chk("wrap1", istek_al(1), 32'h0000_0000);

        // randomized traffic
        ong_mod = 2'd2;
        for (int i = 0; i < 400; i++) begin
            gecikme = $urandom_range(0, 2);
            tik($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}
                    ^ 32'h4000_0000,
                $urandom_range(0, 9) < 7);
        end

        // reset in the middle of a request
        bosa_bekle();
        gecikme = 1;
        for (int i = 0; i < 10 && !m_mesgul; i++) tik(0, 0, '0, 1);
        sifirla();
        gecikme = 0;
        istekler.delete();
        for (int i = 0; i < 8; i++) tik(0, 0, '0, 1);
        chk("post_reset_req", istek_al(0), BAS);

        $display("[TB] %0d tests run, %0d failed", testler, hatalar);
        $finish;
    end

endmodule
